// File: rtl/fios_pkg.sv
// Shared types and sizing helpers for the FIOS BRAM loader.
package fios_pkg;

  // Number of 17-bit words per operand for a given operand bit width.
  function automatic int unsigned fios_words(input int unsigned width);
    return (width + 1) / 17 + 1;
  endfunction

  // Operand selector presented to the core alongside each streamed word.
  typedef enum logic [1:0] {
    P_PRIME0 = 2'd0,
    P        = 2'd1,
    A        = 2'd2,
    B        = 2'd3
  } op_sel_t;

  // Loader sequencing states; StPerfWr is only reachable with the cycle counter built in.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StKick,
    StWaitRes,
    StPerfWr,
    StDone
  } ld_state_t;

endpackage

// File: rtl/fios_bram_addr_gen.sv
// Word counter with terminal-count flag and byte-address formation, reused by the
// operand read phase and the result write phase of the loader.
module fios_bram_addr_gen #(
  parameter int unsigned CntW = 6
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            inc_i,
  input  logic [CntW-1:0] last_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o,
  output logic [31:0]     byte_addr_o
);

  logic [CntW-1:0] cnt_q;

  // Word counter: clear has priority over increment.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o       = cnt_q;
  assign tc_o        = (cnt_q == last_i);
  assign byte_addr_o = {{(32 - CntW - 2){1'b0}}, cnt_q, 2'b00};

endmodule

// File: rtl/fios_bram_loader.sv
// FIOS-side BRAM master: streams p'_0, p, a, b into the core, kicks it, and stores the
// result words back at BRAM word 0 onward.
// Optional feature macro: FIOS_LOADER_PERF_CNT_EN adds cycles_o and stores the
// start-to-done cycle count at word S after the result.
module fios_bram_loader
  import fios_pkg::*;
#(
  parameter  int unsigned WIDTH = 256,
  localparam int unsigned S     = fios_words(WIDTH),
  localparam int unsigned IdxW  = $clog2(S)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  output logic            done_o,
  output logic            bram_en_o,
  output logic [3:0]      bram_we_o,
  output logic [31:0]     bram_addr_o,
  output logic [31:0]     bram_din_o,
  input  logic [31:0]     bram_dout_i,
  output logic            op_valid_o,
  output logic [1:0]      op_sel_o,
  output logic [IdxW-1:0] op_idx_o,
  output logic [16:0]     op_data_o,
  output logic            core_start_o,
  input  logic            res_valid_i,
  input  logic [16:0]     res_data_i
`ifdef FIOS_LOADER_PERF_CNT_EN
  ,
  output logic [31:0]     cycles_o
`endif
);

  localparam int unsigned CntW = $clog2(3 * S + 1);

  ld_state_t       state_q, state_d;
  logic            start_ok;
  logic            cnt_clear, cnt_inc, cnt_tc;
  logic [CntW-1:0] cnt_last, cnt;
  logic [31:0]     word_addr;
  logic            rd_valid_q;
  logic [CntW-1:0] rd_idx_q;
  logic [CntW-1:0] rel_idx;
  logic            wr_pend_q;
  logic [16:0]     wr_data_q;
  logic            res_take;
  logic            unused_dout;

  assign unused_dout = ^bram_dout_i[31:17];

`ifdef FIOS_LOADER_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;
`endif

  fios_bram_addr_gen #(
    .CntW (CntW)
  ) u_addr_gen (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clear_i     (cnt_clear),
    .inc_i       (cnt_inc),
    .last_i      (cnt_last),
    .cnt_o       (cnt),
    .tc_o        (cnt_tc),
    .byte_addr_o (word_addr)
  );

  // Counter restarts on an accepted start and again before the result phase.
  assign cnt_clear = start_ok || (state_q == StKick);

  // Accept a result word only while a slot among the S results is still free.
  assign res_take = (state_q == StWaitRes) && res_valid_i && !(wr_pend_q && cnt_tc);

  // Next-state logic and BRAM/core control outputs.
  always_comb begin
    state_d      = state_q;
    start_ok     = 1'b0;
    cnt_inc      = 1'b0;
    cnt_last     = CntW'(3 * S);
    bram_en_o    = 1'b0;
    bram_we_o    = 4'h0;
    bram_addr_o  = 32'h0;
    bram_din_o   = 32'h0;
    core_start_o = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        bram_en_o   = 1'b1;
        bram_addr_o = word_addr;
        cnt_inc     = 1'b1;
        if (cnt_tc) state_d = StDrain;
      end
      StDrain: state_d = StKick;
      StKick: begin
        core_start_o = 1'b1;
        state_d      = StWaitRes;
      end
      StWaitRes: begin
        cnt_last = CntW'(S - 1);
        if (wr_pend_q) begin
          bram_en_o   = 1'b1;
          bram_we_o   = 4'hf;
          bram_addr_o = word_addr;
          bram_din_o  = {15'b0, wr_data_q};
          cnt_inc     = 1'b1;
`ifdef FIOS_LOADER_PERF_CNT_EN
          if (cnt_tc) state_d = StPerfWr;
`else
          if (cnt_tc) state_d = StDone;
`endif
        end
      end
`ifdef FIOS_LOADER_PERF_CNT_EN
      StPerfWr: begin
        // Counter sits at S here; store the value cycles_o will hold once done rises.
        bram_en_o   = 1'b1;
        bram_we_o   = 4'hf;
        bram_addr_o = word_addr;
        bram_din_o  = cycles_q + 32'd1;
        state_d     = StDone;
      end
`endif
      StDone: begin
        done_o = 1'b1;
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Read-return tracking and result-write staging registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      rd_valid_q <= (state_q == StLoad);
      rd_idx_q   <= cnt;
      wr_pend_q  <= res_take;
      if (res_take) wr_data_q <= res_data_i;
    end
  end

  assign rel_idx = rd_idx_q - 1'b1;

  // Operand stream toward the core, decoded from the delayed read word index.
  always_comb begin
    op_valid_o = rd_valid_q;
    op_sel_o   = P_PRIME0;
    op_idx_o   = '0;
    op_data_o  = '0;
    if (rd_valid_q) begin
      op_data_o = bram_dout_i[16:0];
      if (rd_idx_q != '0) begin
        op_sel_o = 2'(32'd1 + 32'(rel_idx) / S);
        op_idx_o = IdxW'(32'(rel_idx) % S);
      end
    end
  end

`ifdef FIOS_LOADER_PERF_CNT_EN
  // Cycle counter: cleared on accepted start, runs while busy, frozen in idle/done.
  always_comb begin
    cycles_d = cycles_q;
    if (start_ok) begin
      cycles_d = 32'd0;
    end else if (state_q != StIdle && state_q != StDone) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_fios_bram_loader.sv
// Self-checking bench for fios_bram_loader with a BRAM model, a core model and a
// reference of the operand stream built from the operand layout.
module tb_fios_bram_loader;

  localparam int unsigned W  = 256;
  localparam int unsigned S  = (W + 1) / 17 + 1;
  localparam int unsigned NW = 3 * S + 1;
  localparam int unsigned IW = $clog2(S);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          res_valid = 1'b0;
  logic [16:0]   res_data = '0;
  logic          done_o, bram_en_o, op_valid_o, core_start_o;
  logic [3:0]    bram_we_o;
  logic [31:0]   bram_addr_o, bram_din_o, bram_dout;
  logic [1:0]    op_sel_o;
  logic [IW-1:0] op_idx_o;
  logic [16:0]   op_data_o;
`ifdef FIOS_LOADER_PERF_CNT_EN
  logic [31:0]   cycles;
`endif

  always #5 clock = ~clock;

  fios_bram_loader #(
    .WIDTH (W)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset_n),
    .start_i      (start),
    .done_o       (done_o),
    .bram_en_o    (bram_en_o),
    .bram_we_o    (bram_we_o),
    .bram_addr_o  (bram_addr_o),
    .bram_din_o   (bram_din_o),
    .bram_dout_i  (bram_dout),
    .op_valid_o   (op_valid_o),
    .op_sel_o     (op_sel_o),
    .op_idx_o     (op_idx_o),
    .op_data_o    (op_data_o),
    .core_start_o (core_start_o),
    .res_valid_i  (res_valid),
    .res_data_i   (res_data)
`ifdef FIOS_LOADER_PERF_CNT_EN
    ,
    .cycles_o     (cycles)
`endif
  );

  // BRAM model: host port for preloading, DUT port with one-cycle read latency.
  logic [31:0] mem [0:63];
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;

  always @(posedge clock) begin
    if (host_we) begin
      mem[host_addr] <= host_wdata;
    end else if (bram_en_o) begin
      if (bram_we_o == 4'hf) mem[bram_addr_o[7:2]] <= bram_din_o;
      bram_dout <= mem[bram_addr_o[7:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference: operands, expected stream, preload image, core results.
  logic [16:0] opnd [4][S];
  int          exp_sel [NW];
  int          exp_idx [NW];
  logic [16:0] exp_dat [NW];
  logic [31:0] pre_w [NW];
  logic [16:0] res_w [S];

  int cyc = 0;
  int rd_pos, first_rd, last_rd, n_val, first_v, last_v, n_kick, kick_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then observe outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (bram_en_o && bram_we_o == 4'h0) begin
      check("rd_addr", bram_addr_o, 32'(rd_pos * 4));
      if (rd_pos == 0) first_rd = cyc;
      last_rd = cyc;
      rd_pos++;
    end
    if (bram_we_o != 4'h0) check("we_full", 32'(bram_we_o), 32'hf);
    if (op_valid_o) begin
      if (n_val == 0) first_v = cyc;
      last_v = cyc;
      if (n_val < int'(NW)) begin
        check("op_sel", 32'(op_sel_o), 32'(exp_sel[n_val]));
        check("op_idx", 32'(op_idx_o), 32'(exp_idx[n_val]));
        check("op_data", 32'(op_data_o), 32'(exp_dat[n_val]));
      end
      n_val++;
    end
    if (core_start_o) begin
      n_kick++;
      kick_cyc = cyc;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, 32'(done_o), 32'h0);
    check({tag, "_en"}, 32'(bram_en_o), 32'h0);
    check({tag, "_we"}, 32'(bram_we_o), 32'h0);
    check({tag, "_addr"}, bram_addr_o, 32'h0);
    check({tag, "_din"}, bram_din_o, 32'h0);
    check({tag, "_opv"}, 32'(op_valid_o), 32'h0);
    check({tag, "_sel"}, 32'(op_sel_o), 32'h0);
    check({tag, "_idx"}, 32'(op_idx_o), 32'h0);
    check({tag, "_opd"}, 32'(op_data_o), 32'h0);
    check({tag, "_kick"}, 32'(core_start_o), 32'h0);
`ifdef FIOS_LOADER_PERF_CNT_EN
    check({tag, "_cycles"}, cycles, 32'h0);
`endif
  endtask

  // Random operands, expected stream in p'_0, p, a, b order, preloaded through the host port.
  task automatic load_job(input bit ramp);
    logic [31:0] junk;
    int pos;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < int'(S); i++) opnd[o][i] = 17'($urandom);
    end
    exp_sel[0] = 0;
    exp_idx[0] = 0;
    exp_dat[0] = opnd[0][0];
    pos = 1;
    for (int o = 1; o < 4; o++) begin
      for (int i = 0; i < int'(S); i++) begin
        exp_sel[pos] = o;
        exp_idx[pos] = i;
        exp_dat[pos] = opnd[o][i];
        pos++;
      end
    end
    for (int k = 0; k < int'(NW); k++) begin
      junk = $urandom;
      pre_w[k] = {junk[31:17], exp_dat[k]};
      host_we = 1'b1;
      host_addr = 6'(k);
      host_wdata = pre_w[k];
      tick();
    end
    host_we = 1'b0;
    for (int i = 0; i < int'(S); i++) res_w[i] = ramp ? 17'(i + 1) : 17'($urandom);
  endtask

  task automatic run_job(input bit ramp, input int gap_max, input bit poke, input int abort_at);
    int n;
    int g;
    load_job(ramp);
    rd_pos = 0; n_val = 0; n_kick = 0; first_rd = 0; last_rd = 0;
    first_v = 0; last_v = 0; kick_cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    check("first_rd_en", 32'(bram_en_o), 32'h1);
    check("first_rd_addr", bram_addr_o, 32'h0);
    for (int guard = 0; guard < 300 && n_kick == 0; guard++) begin
      start = poke && guard == 10;
      tick();
      n++;
      start = 1'b0;
    end
    check("kick_seen", 32'(n_kick), 32'h1);
    check("rd_count", 32'(rd_pos), 32'(NW));
    check("op_count", 32'(n_val), 32'(NW));
    check("op_span", 32'(last_v - first_v + 1), 32'(NW));
    check("op_latency", 32'(first_v - first_rd), 32'h1);
    check("kick_delay", 32'(kick_cyc - last_rd), 32'h2);
    tick();
    n++;
    for (int k = 0; k < int'(S); k++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        tick();
        n++;
        check("done_early", 32'(done_o), 32'h0);
      end
      res_valid = 1'b1;
      res_data = res_w[k];
      start = poke && k == 3;
      tick();
      n++;
      start = 1'b0;
      res_valid = 1'b0;
      check("done_early", 32'(done_o), 32'h0);
      if (abort_at == k + 1) begin
        tick();
        #2 reset_n = 1'b0;
        #1;
        check_zero("abort");
        for (int j = 0; j <= k; j++) check("abort_kept_res", mem[j], {15'b0, res_w[j]});
        for (int j = k + 1; j < int'(S); j++) check("abort_kept_pre", mem[j], pre_w[j]);
        return;
      end
    end
`ifdef FIOS_LOADER_PERF_CNT_EN
    tick();
    n++;
    check("done_early", 32'(done_o), 32'h0);
`endif
    tick();
    n++;
    check("done_rise", 32'(done_o), 32'h1);
    check("kick_once", 32'(n_kick), 32'h1);
    for (int k = 0; k < int'(S); k++) check("res_word", mem[k], {15'b0, res_w[k]});
`ifdef FIOS_LOADER_PERF_CNT_EN
    check("cycles", cycles, 32'(n));
    check("perf_word", mem[S], 32'(n));
`else
    check("word_s_kept", mem[S], pre_w[S]);
`endif
    check("b_kept", mem[3 * S], pre_w[3 * S]);
    // A stray result word after completion must not reach BRAM.
    res_valid = 1'b1;
    res_data = 17'h1ffff;
    tick();
    res_valid = 1'b0;
    check("stray_en", 32'(bram_en_o), 32'h0);
    tick();
    check("done_hold", 32'(done_o), 32'h1);
    check("stray_word", mem[S - 1], {15'b0, res_w[S - 1]});
  endtask

  initial begin
    rd_pos = 0; n_val = 0; n_kick = 0;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();
    check("idle_done", 32'(done_o), 32'h0);

    // Ramp results, back-to-back core.
    run_job(1'b1, 0, 1'b0, 0);
    // Random results with gaps, start poked during load and result phases.
    run_job(1'b0, 5, 1'b1, 0);

    // Start while done: done drops and a new load begins, then reset aborts it.
    rd_pos = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done_drop", 32'(done_o), 32'h0);
    check("restart_en", 32'(bram_en_o), 32'h1);
    check("restart_addr0", bram_addr_o, 32'h0);
    tick();
    check("restart_addr1", bram_addr_o, 32'h4);
    #2 reset_n = 1'b0;
    #1;
    check_zero("rst_load");
    tick();
    reset_n = 1'b1;
    tick();

    // Reset during the result phase after 7 words, then a full restart.
    run_job(1'b0, 3, 1'b0, 7);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("post_abort_idle", 32'(done_o), 32'h0);
    run_job(1'b0, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fios_bram_loader.md
# fios_bram_loader

FIOS-side Block RAM master that serves the operand layout written by the host/bench. On `start_i` it reads p'_0, p, a and b from BRAM and streams them as 17-bit words into the FIOS core. It then starts the core, writes the s result words back into BRAM from word 0, and raises `done_o`. It sits between the BRAM port B and the FIOS multiplier core inside the top block design.

## Interface
- `WIDTH`, 256, operand bit width; S = (WIDTH+1)/17+1 words per operand (S=16 at 256).
- `clock_i`  in  1  single design clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start request, sampled high for one cycle.
- `done_o`  out  1  result stored in BRAM; held high until the next accepted start.
- `bram_en_o`  out  1  BRAM port enable.
- `bram_we_o`  out  4  byte write enable; 4'hf on writes, 0 otherwise.
- `bram_addr_o`  out  32  byte address = word index << 2.
- `bram_din_o`  out  32  write data; {15'b0, 17-bit word}.
- `bram_dout_i`  in  32  read data, valid one cycle after the address; bits [16:0] used.
- `op_valid_o`  out  1  operand word valid toward the core.
- `op_sel_o`  out  2  0 = p'_0, 1 = p, 2 = a, 3 = b.
- `op_idx_o`  out  $clog2(S)  word index inside the operand, LSW first.
- `op_data_o`  out  17  operand word.
- `core_start_o`  out  1  one-cycle core start pulse.
- `res_valid_i`  in  1  result word valid from the core; no backpressure.
- `res_data_i`  in  17  result word, LSW first.

## Operation
- BRAM word map: word 0 = p'_0; words 1..S = p; S+1..2S = a; 2S+1..3S = b. Result goes to words 0..S-1 and overwrites p'_0 and p.
- FSM states:
  - IDLE: if `start_i`, go to LOAD.
  - LOAD: issue reads for words 0..3S, one per cycle; after word 3S, go to DRAIN.
  - DRAIN: one cycle to catch the last read data, then go to KICK.
  - KICK: `core_start_o`=1 for one cycle, then go to WAIT_RES.
  - WAIT_RES: each `res_valid_i` writes to word `res_cnt`; after word S-1, go to DONE.
  - DONE: `done_o`=1; `start_i` clears `done_o` and goes to LOAD.
- `op_sel_o` and `op_idx_o` are derived from the delayed read word index: index 0 gives sel 0, idx 0; index k≥1 gives sel 1+(k-1)/S, idx (k-1)%S.
- `start_i` is ignored in LOAD, DRAIN, KICK and WAIT_RES.
- `res_valid_i` outside WAIT_RES is ignored. Words beyond S are ignored.
- Reset mid-operation returns to IDLE immediately. Partial BRAM writes are left in place.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Start is sampled at edge T; the first read address (word 0) is driven from T+1.
- Read issued at cycle t gives `op_valid_o`/`op_data_o` at t+1. There are exactly 3S+1 consecutive valid cycles with no gaps.
- `core_start_o` asserts 2 cycles after the last read address.
- `res_valid_i` at cycle t gives a registered BRAM write at t+1.
- `done_o` rises the cycle after the last result write, i.e. 2 cycles after the S-th `res_valid_i`.
- `bram_en_o` is high only during read issue and write cycles.

## Configuration
- `FIOS_LOADER_PERF_CNT_EN`
  - Defined: adds output `cycles_o[31:0]`. It counts clocks from start acceptance to the `done_o` rise, freezes in DONE and clears on the next start. The value is also written to BRAM word S one cycle after the last result write, so `done_o` is delayed by 1 cycle.
  - Undefined: no port, no extra write, timing as above.

## Structure
- `fios_pkg`:
  - function computing S from WIDTH;
  - `op_sel_t` enum (P_PRIME0, P, A, B);
  - loader state enum.
- One sub-module, `fios_bram_addr_gen`: word counter, terminal-count flag and byte-address formation, shared by the read and write phases.

## Test plan
- WIDTH=256 (S=16): start → 49 reads at byte addresses 0x00..0xC0 in order. `op_valid_o` stays high for 49 consecutive cycles with sel/idx (0,0),(1,0)..(1,15),(2,0)..(3,15). `core_start_o` pulses once.
- Core model returns 16 words 0x00001..0x00010 back-to-back → BRAM words 0..15 hold 1..16; `done_o` is high 2 cycles after the last `res_valid_i`.
- Result words with random gaps (up to 5 idle cycles) → same BRAM contents; `done_o` is not raised early.
- `start_i` pulsed during LOAD and WAIT_RES → ignored; exactly one `core_start_o`. `start_i` in DONE → `done_o` drops next cycle and a new load begins.
- `reset_i` low during WAIT_RES after 7 words → all outputs 0 asynchronously. Words 0..6 remain written. A restart runs a full sequence.
- `FIOS_LOADER_PERF_CNT_EN` defined, zero-gap core → `cycles_o` equals the measured start-to-done count. Word 16 holds the same value.
